// File: rtl/led_mode_pkg.sv
// Shared definitions for the LED pattern sequencer: mode count, widths,
// sequencer FSM encoding and a small one-hot helper.
package led_mode_pkg;

    localparam int NUM_MODES = 4;
    localparam int MODE_W    = 2;
    localparam int LED_W     = 8;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } seq_state_e;

    // Restart mask that targets only the engine behind the given mode number.
    function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [MODE_W-1:0] mode);
        mode_onehot       = '0;
        mode_onehot[mode] = 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge detect. Emits one clk-wide pulse per accepted press.
module btn_debounce
    import led_mode_pkg::*;
#(
    parameter int DEB_LEN = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEB_LEN);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    // Count consecutive synchronized samples that disagree with the accepted
    // level; the level flips on the DEB_LEN-th one, any agreeing sample restarts.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_LEN - 1)) begin
                level_d = sync2_q;
                pulse_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/led_mode_sequencer.sv
// Control and output stage for the four-mode LED pattern design: step
// prescaler, mode selection (button or auto-cycle), engine restart and LED mux.
module led_mode_sequencer
    import led_mode_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int DEB_LEN    = 16,
    parameter int AUTO_STEPS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 btn_next,
    input  logic                 auto_en,
    input  logic [LED_W-1:0]     mode0_out,
    input  logic [LED_W-1:0]     mode1_out,
    input  logic [LED_W-1:0]     mode2_out,
    input  logic [LED_W-1:0]     mode3_out,
    output logic                 en_tick,
    output logic [NUM_MODES-1:0] mode_rst,
    output logic [MODE_W-1:0]    mode_sel,
    output logic [LED_W-1:0]     LED
);

    localparam int PRE_W  = $clog2(TICK_DIV);
    localparam int AUTO_W = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;

    seq_state_e           state_q, state_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic                 tick_q, tick_d;
    logic [AUTO_W-1:0]    step_q, step_d;
    logic [MODE_W-1:0]    sel_q, sel_d;
    logic [NUM_MODES-1:0] rst_q, rst_d;
    logic [LED_W-1:0]     led_q, led_d;

    logic                 btn_pulse;
    logic                 auto_adv;
    logic                 advance;
    logic [MODE_W-1:0]    next_sel;
    logic [LED_W-1:0]     sel_pattern;

    btn_debounce #(
        .DEB_LEN (DEB_LEN)
    ) u_btn_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_next),
        .pulse (btn_pulse)
    );

    // Pattern of the currently selected engine, ahead of the LED register.
    always_comb begin
        sel_pattern = mode0_out;
        case (sel_q)
            2'd0:    sel_pattern = mode0_out;
            2'd1:    sel_pattern = mode1_out;
            2'd2:    sel_pattern = mode2_out;
            default: sel_pattern = mode3_out;
        endcase
    end

    // Next-state logic: INIT and SWITCH each last one clk with the prescaler
    // parked at zero; RUN counts steps and advances on a press or auto timeout.
    always_comb begin
        auto_adv = (state_q == ST_RUN) && auto_en && tick_q &&
                   (step_q == AUTO_W'(AUTO_STEPS - 1));
        advance  = (state_q == ST_RUN) && (btn_pulse || auto_adv);
        next_sel = sel_q + 1'b1;

        state_d = state_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        step_d  = step_q;
        sel_d   = sel_q;
        rst_d   = rst_q;
        led_d   = led_q;

        case (state_q)
            ST_INIT, ST_SWITCH: begin
                state_d = ST_RUN;
                rst_d   = '0;
                pre_d   = '0;
            end
            ST_RUN: begin
                led_d = sel_pattern;
                if (advance) begin
                    state_d = ST_SWITCH;
                    sel_d   = next_sel;
                    rst_d   = mode_onehot(next_sel);
                    pre_d   = '0;
                    step_d  = '0;
                end else begin
                    if (pre_q == PRE_W'(TICK_DIV - 1)) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                    if (!auto_en) begin
                        step_d = '0;
                    end else if (tick_q) begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                rst_d   = '1;
                pre_d   = '0;
                step_d  = '0;
            end
        endcase
    end

    // Sequencer registers; every output is driven straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            step_q  <= '0;
            sel_q   <= '0;
            rst_q   <= '1;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            sel_q   <= sel_d;
            rst_q   <= rst_d;
            led_q   <= led_d;
        end
    end

    assign en_tick  = tick_q;
    assign mode_rst = rst_q;
    assign mode_sel = sel_q;
    assign LED      = led_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized bench for led_mode_sequencer with small timing parameters,
// simple counting pattern engines and a behavioural reference model.
module tb_led_mode_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int DEB_LEN    = 3;
    localparam int AUTO_STEPS = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next;
    logic       auto_en;
    logic [7:0] mode0_out, mode1_out, mode2_out, mode3_out;
    logic       en_tick;
    logic [3:0] mode_rst;
    logic [1:0] mode_sel;
    logic [7:0] LED;

    int n_cmp  = 0;
    int n_fail = 0;
    logic chk_on = 1'b0;

    led_mode_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .DEB_LEN    (DEB_LEN),
        .AUTO_STEPS (AUTO_STEPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_next  (btn_next),
        .auto_en   (auto_en),
        .mode0_out (mode0_out),
        .mode1_out (mode1_out),
        .mode2_out (mode2_out),
        .mode3_out (mode3_out),
        .en_tick   (en_tick),
        .mode_rst  (mode_rst),
        .mode_sel  (mode_sel),
        .LED       (LED)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Pattern engines: each shows 8'h10*i plus its own step count.
    logic [7:0] eng_cnt [4];
    logic [7:0] eng_out [4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) eng_cnt[i] <= 8'h00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (mode_rst[i])  eng_cnt[i] <= 8'h00;
                else if (en_tick) eng_cnt[i] <= eng_cnt[i] + 8'h01;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) eng_out[i] = 8'(8'h10 * i) + eng_cnt[i];
    end

    assign mode0_out = eng_out[0];
    assign mode1_out = eng_out[1];
    assign mode2_out = eng_out[2];
    assign mode3_out = eng_out[3];

    // Reference model: m_age counts running clks since a (re)start, ticks land on
    // multiples of TICK_DIV; the button is judged on a window of raw samples.
    int         m_mode;
    logic [3:0] m_rst;
    logic       m_tick;
    logic [7:0] m_led;
    logic       m_running;
    int         m_age;
    int         m_steps;
    logic       m_deb;
    logic       m_pulse;
    logic       raw_hist[$];
    logic       m_adv;
    logic       m_flip;
    logic [7:0] m_pat;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode    = 0;
            m_rst     = 4'hF;
            m_tick    = 1'b0;
            m_led     = 8'h00;
            m_running = 1'b0;
            m_age     = 0;
            m_steps   = 0;
            m_deb     = 1'b0;
            m_pulse   = 1'b0;
            raw_hist.delete();
            for (int k = 0; k < DEB_LEN + 2; k++) raw_hist.push_back(1'b0);
        end else begin
            m_pat = eng_out[m_mode];
            m_adv = m_running &&
                    (m_pulse || (auto_en && m_tick && m_steps == AUTO_STEPS - 1));

            raw_hist.push_back(btn_next);
            void'(raw_hist.pop_front());
            m_flip = 1'b1;
            for (int k = 0; k < DEB_LEN; k++) begin
                if (raw_hist[k] == m_deb) m_flip = 1'b0;
            end

            if (!m_running) begin
                m_running = 1'b1;
                m_rst     = 4'h0;
                m_tick    = 1'b0;
                m_age     = 0;
            end else if (m_adv) begin
                m_mode    = (m_mode + 1) % 4;
                m_rst     = 4'(1 << m_mode);
                m_running = 1'b0;
                m_tick    = 1'b0;
                m_age     = 0;
                m_steps   = 0;
                m_led     = m_pat;
            end else begin
                if (!auto_en)    m_steps = 0;
                else if (m_tick) m_steps = m_steps + 1;
                m_age  = m_age + 1;
                m_tick = (m_age % TICK_DIV) == 0;
                m_led  = m_pat;
            end

            m_pulse = m_flip && !m_deb;
            if (m_flip) m_deb = !m_deb;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("en_tick",  32'(en_tick),  32'(m_tick));
            checkOutput("mode_rst", 32'(mode_rst), 32'(m_rst));
            checkOutput("mode_sel", 32'(mode_sel), 32'(m_mode));
            checkOutput("LED",      32'(LED),      32'(m_led));
        end
    end

    // Drive both inputs and let the given number of clks elapse.
    task automatic applyStimulus(input logic btn, input logic aut, input int cycles);
        btn_next = btn;
        auto_en  = aut;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        logic found;
        reset    = 1'b1;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);

        $display("[TB] reset release and free-running mode 0");
        #2 reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] long button hold");
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] short glitches");
        for (int g = 0; g < 10; g++) begin
            applyStimulus(1'b1, 1'b0, $urandom_range(1, 2));
            applyStimulus(1'b0, 1'b0, $urandom_range(1, 6));
        end
        applyStimulus(1'b0, 1'b0, 10);

        $display("[TB] auto cycling");
        applyStimulus(1'b0, 1'b1, 70);

        $display("[TB] press coincident with auto advance");
        found = 1'b0;
        for (int w = 0; w < 200 && !found; w++) begin
            @(negedge clk);
            if (m_running && m_age == TICK_DIV - 1 && m_steps == 0 && !m_deb) found = 1'b1;
        end
        checkOutput("wait_coincide", 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1, 6);
        applyStimulus(1'b0, 1'b1, 10);

        $display("[TB] reset during switch into mode 2");
        found = 1'b0;
        for (int w = 0; w < 300 && !found; w++) begin
            @(negedge clk);
            if (!m_running && m_mode == 2 && m_rst == 4'b0100) found = 1'b1;
        end
        checkOutput("wait_switch2", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_mode_sel", 32'(mode_sel), 32'd0);
        checkOutput("async_LED",      32'(LED),      32'h00);
        checkOutput("async_mode_rst", 32'(mode_rst), 32'hF);
        checkOutput("async_en_tick",  32'(en_tick),  32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        auto_en = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 40; r++) begin
            logic a;
            a = ($urandom_range(0, 3) != 0);
            applyStimulus(1'($urandom_range(0, 1)), a, $urandom_range(1, 8));
            applyStimulus(1'b0, a, $urandom_range(1, 12));
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
